// File: rtl/led_pwm_driver_pkg.sv
// Shared definitions for the LED PWM driver: lamp-test state encoding,
// default parameter values and a width helper.
package led_pwm_driver_pkg;

   localparam int unsigned C_NUM_LEDS         = 16;
   localparam int unsigned C_PWM_BITS         = 8;
   localparam int unsigned C_STRETCH_CYCLES   = 2000000;   // 50 ms at 40 MHz
   localparam int unsigned C_LAMP_STEP_CYCLES = 10000000;  // 0.25 s at 40 MHz

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALL_ON = 2'd1,
      ST_WALK   = 2'd2
   } lamp_state_t;

   // Counter width able to hold value-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned value);
      if (value > 1) return $clog2(value);
      return 1;
   endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Per-channel pulse stretcher: guarantees a minimum visible on-time for
// every rising edge of the registered LED request.
//   clock, reset      : fabric clock, async active-high reset
//   i_led_q           : registered LED request for this channel
//   o_stretched_c     : combinational stretched request (request OR count active)
module led_pulse_stretch
   import led_pwm_driver_pkg::*;
#(
   parameter int unsigned G_STRETCH_CYCLES = C_STRETCH_CYCLES
)(
   input  logic clock,
   input  logic reset,
   input  logic i_led_q,
   output logic o_stretched_c
);

   localparam int unsigned      CNT_W    = clog2_min1(G_STRETCH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(G_STRETCH_CYCLES - 1);

   logic             r_led_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;

   assign w_rise = i_led_q & ~r_led_prev;

   // Rising edge (re)loads; the count only drains once the request drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_led_prev <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_led_prev <= i_led_q;
         if (w_rise) begin
            r_cnt <= CNT_LOAD;
         end else if (!i_led_q && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign o_stretched_c = i_led_q | (r_cnt != '0);

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: input registration, per-channel pulse stretching,
// global PWM dimming, blanking and a lamp-test sequencer.
//   clock, reset      : 40 MHz fabric clock, async active-high reset
//   led_i             : logical LED pattern
//   brightness_i      : PWM duty setting (all-ones = fully on)
//   blank_i           : forces all outputs off
//   lamp_test_i       : single-cycle lamp-test start pulse
//   led_o             : registered LED pin drive
//   lamp_test_busy_o  : high while the lamp test is running
module led_pwm_driver
   import led_pwm_driver_pkg::*;
#(
   parameter int unsigned G_NUM_LEDS         = C_NUM_LEDS,
   parameter int unsigned G_PWM_BITS         = C_PWM_BITS,
   parameter int unsigned G_STRETCH_CYCLES   = C_STRETCH_CYCLES,
   parameter int unsigned G_LAMP_STEP_CYCLES = C_LAMP_STEP_CYCLES
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [G_NUM_LEDS-1:0] led_i,
   input  logic [G_PWM_BITS-1:0] brightness_i,
   input  logic                  blank_i,
   input  logic                  lamp_test_i,
   output logic [G_NUM_LEDS-1:0] led_o,
   output logic                  lamp_test_busy_o
);

   localparam int unsigned            STEP_W    = clog2_min1(G_LAMP_STEP_CYCLES);
   localparam int unsigned            IDX_W     = clog2_min1(G_NUM_LEDS);
   localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(G_LAMP_STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(G_NUM_LEDS - 1);
   localparam logic [G_PWM_BITS-1:0]  PWM_MAX   = '1;

   logic [G_NUM_LEDS-1:0] r_led_q;
   logic [G_PWM_BITS-1:0] r_pwm_cnt;
   logic [G_PWM_BITS-1:0] r_brightness_q;
   lamp_state_t           r_state;
   logic [STEP_W-1:0]     r_step;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_busy;
   logic [G_NUM_LEDS-1:0] r_led_o;

   logic                  w_pwm_on;
   logic [G_NUM_LEDS-1:0] w_stretched;
   logic [G_NUM_LEDS-1:0] w_lamp_pattern;

   // Input registration.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_led_q <= '0;
      end else begin
         r_led_q <= led_i;
      end
   end

   // Free-running PWM counter; duty is sampled only at the period boundary.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pwm_cnt      <= '0;
         r_brightness_q <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + G_PWM_BITS'(1);
         if (r_pwm_cnt == PWM_MAX) begin
            r_brightness_q <= brightness_i;
         end
      end
   end

   // All-ones is special-cased so full brightness has no off slot.
   assign w_pwm_on = (r_brightness_q == PWM_MAX) || (r_pwm_cnt < r_brightness_q);

   for (genvar g = 0; g < int'(G_NUM_LEDS); g++) begin : g_stretch
      led_pulse_stretch #(
         .G_STRETCH_CYCLES (G_STRETCH_CYCLES)
      ) u_stretch (
         .clock         (clock),
         .reset         (reset),
         .i_led_q       (r_led_q[g]),
         .o_stretched_c (w_stretched[g])
      );
   end

   // Lamp-test sequencer; start requests are ignored outside IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_step  <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (lamp_test_i) begin
                  r_state <= ST_ALL_ON;
                  r_step  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_ALL_ON: begin
               if (r_step == STEP_LAST) begin
                  r_state <= ST_WALK;
                  r_step  <= '0;
                  r_idx   <= '0;
               end else begin
                  r_step <= r_step + STEP_W'(1);
               end
            end
            ST_WALK: begin
               if (r_step == STEP_LAST) begin
                  r_step <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_IDLE;
                     r_idx   <= '0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_step <= r_step + STEP_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_lamp_pattern = '0;
      case (r_state)
         ST_ALL_ON: w_lamp_pattern = '1;
         ST_WALK:   w_lamp_pattern = G_NUM_LEDS'(1) << r_idx;
         default:   w_lamp_pattern = '0;
      endcase
   end

   // Output priority: blank, then lamp test (not dimmed), then dimmed pattern.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_led_o <= '0;
      end else if (blank_i) begin
         r_led_o <= '0;
      end else if (r_state != ST_IDLE) begin
         r_led_o <= w_lamp_pattern;
      end else begin
         r_led_o <= w_stretched & {G_NUM_LEDS{w_pwm_on}};
      end
   end

   assign led_o            = r_led_o;
   assign lamp_test_busy_o = r_busy;

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 The block SHALL have parameter G_NUM_LEDS, default 16, giving the number of LED channels.
REQ-002 The block SHALL have parameter G_PWM_BITS, default 8, giving the PWM counter width.
REQ-003 The block SHALL have parameter G_STRETCH_CYCLES, default 2000000, giving the minimum on-time per LED rising edge (50 ms at 40 MHz).
REQ-004 The block SHALL have parameter G_LAMP_STEP_CYCLES, default 10000000, giving the lamp-test step length (0.25 s).
REQ-005 The block SHALL have port clock, input, 1 bit: the 40 MHz fabric clock, which is the only clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port led_i, input, G_NUM_LEDS bits: logical LED pattern from the LED control stage.
REQ-008 The block SHALL have port brightness_i, input, G_PWM_BITS bits: the duty-cycle setting.
REQ-009 The block SHALL have port blank_i, input, 1 bit: forces all LEDs off.
REQ-010 The block SHALL have port lamp_test_i, input, 1 bit: a single-cycle lamp-test start pulse.
REQ-011 The block SHALL have port led_o, output, G_NUM_LEDS bits: the registered drive to the physical LED pins.
REQ-012 The block SHALL have port lamp_test_busy_o, output, 1 bit: high while the lamp-test FSM is not in IDLE.

Function
REQ-013 led_i SHALL be registered once (led_q) before any processing.
REQ-014 The PWM counter SHALL be free-running over G_PWM_BITS and wrap from 2^G_PWM_BITS-1 to 0.
REQ-015 brightness_i SHALL be captured into brightness_q only on the cycle where the PWM counter equals its maximum, so a duty change never truncates a period.
REQ-016 pwm_on SHALL be 1 when brightness_q equals all-ones or pwm_cnt < brightness_q, and 0 otherwise.
REQ-017 As a consequence of REQ-016, brightness 0 SHALL give an always-off output and all-ones SHALL give an always-on output.
REQ-018 Each channel SHALL have a stretch counter that loads G_STRETCH_CYCLES-1 on a rising edge of led_q[n], decrements to 0 when led_q[n] is low, and saturates at 0.
REQ-019 stretched[n] SHALL equal led_q[n] OR (stretch counter != 0).
REQ-020 A new rising edge during an active stretch SHALL reload the stretch counter.
REQ-021 The lamp-test FSM SHALL have the states IDLE, ALL_ON and WALK.
REQ-022 From IDLE, lamp_test_i=1 SHALL move the FSM to ALL_ON and clear the step counter.
REQ-023 In ALL_ON, all LEDs SHALL be on; after G_LAMP_STEP_CYCLES cycles the FSM SHALL move to WALK with index 0.
REQ-024 In WALK, only LED[index] SHALL be on; each G_LAMP_STEP_CYCLES cycles the index SHALL increment, and after index G_NUM_LEDS-1 the FSM SHALL return to IDLE.
REQ-025 lamp_test_i SHALL be ignored while the FSM is not in IDLE, so a test cannot be restarted mid-sequence.
REQ-026 The output priority SHALL be: blank_i forces 0, else lamp test (FSM not IDLE) drives the lamp pattern ungated by PWM, else stretched AND pwm_on.
REQ-027 blank_i SHALL NOT pause or reset the FSM or the stretchers.
REQ-028 led_o SHALL be registered, giving a latency from led_i to led_o of 2 cycles with full brightness.
REQ-029 Latency from blank_i and from the FSM state to led_o SHALL be 1 cycle.
REQ-030 lamp_test_busy_o SHALL be registered and go high the cycle after lamp_test_i is accepted.

Reset
REQ-031 Reset SHALL set led_o=0, lamp_test_busy_o=0, led_q=0, all stretch counters=0, pwm_cnt=0, brightness_q=0, FSM=IDLE, step counter=0 and index=0.
REQ-032 Reset asserted mid-lamp-test or mid-stretch SHALL abort immediately, and no residual pattern SHALL appear after release.
REQ-033 After reset release, LEDs SHALL remain dark until the first PWM wrap loads brightness_q.

Structure
REQ-034 The shared package SHALL hold the FSM state encoding constants (IDLE=0, ALL_ON=1, WALK=2) and the default parameter values.
REQ-035 A per-channel sub-module led_pulse_stretch, holding the edge detector and stretch counter, SHALL be instantiated G_NUM_LEDS times in a generate loop.
REQ-036 Counter widths SHALL be derived with clog2 of the corresponding parameters.

Verification (G_PWM_BITS=3, G_STRETCH_CYCLES=8, G_LAMP_STEP_CYCLES=4, G_NUM_LEDS=16)
REQ-037 Scenario: brightness=7, led_i=16'h00FF held -> led_o=16'h00FF continuously, starting 2 cycles after the first brightness capture.
REQ-038 Scenario: brightness=3, led_i=16'h0001 held -> led_o[0] high exactly 3 of every 8 cycles, aligned to pwm_cnt 0..2.
REQ-039 Scenario: brightness=7, 1-cycle pulse on led_i[5] -> led_o[5] high for exactly 8 cycles; a second pulse 4 cycles later -> 12 cycles high in total.
REQ-040 Scenario: lamp_test_i pulse -> led_o=16'hFFFF for 4 cycles, then 16'h0001, 16'h0002 ... 16'h8000 for 4 cycles each; lamp_test_busy_o high for 68 cycles.
REQ-041 Scenario: during the lamp test, assert blank_i for 10 cycles and pulse lamp_test_i again -> led_o=0 while blanked, the sequence is not restarted, and it completes on the original schedule.
REQ-042 Scenario: async reset asserted mid-WALK and mid-stretch -> led_o=0 and lamp_test_busy_o=0 immediately with no clock edge; after release, output is dark until the next PWM wrap.
